lsu_mem_stage: RTL and testbench

Load/store unit directly downstream of the pipeline's MEM-stage data memory interface. It takes the raw address, store data and access type from the datapath and drives a req/gnt/rvalid data bus with word-aligned address, byte enables and lane-replicated store data. It extracts and sign- or zero-extends load data. It stalls the pipeline for the whole bus transaction and flags misaligned accesses and bus errors.

---
 rtl/rv32_lsu_pkg.sv | 56 +++++
 rtl/lsu_load_align.sv | 28 ++
 rtl/lsu_mem_stage.sv | 150 +++++++++++++++
 tb/tb_lsu_mem_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// FSM state type, byte-enable patterns and store lane helpers.
package rv32_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  // Size code 2'b11 is not a legal RISC-V access; it behaves as a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    case ({1'b0, size})
      F3_SB:   mis = 1'b0;
      F3_SH:   mis = offset[0];
      default: mis = (offset != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] be;
    case ({1'b0, size})
      F3_SB:   be = 4'b0001 << offset;
      F3_SH:   be = offset[1] ? BE_HALF_HI : BE_HALF_LO;
      default: be = BE_WORD;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] lanes;
    case ({1'b0, size})
      F3_SB:   lanes = {4{data[7:0]}};
      F3_SH:   lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extraction: shifts the addressed bytes of the bus word
// down to bit 0 and sign- or zero-extends them according to funct3.
module lsu_load_align
  import rv32_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    result = shifted;
    case (funct3)
      F3_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  result = {24'b0, shifted[7:0]};
      F3_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  result = {16'b0, shifted[15:0]};
      F3_LW:   result = shifted;
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit driving a req/gnt/rvalid bus; stalls the pipe for
// the whole transaction. Optional bus watchdog enabled by `define LSU_TIMEOUT_EN.
module lsu_mem_stage
  import rv32_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [2:0]  mem_funct3_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        lsu_stall_o,
  output logic        load_valid_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i,
  output lsu_state_t  dbg_state
);

  // Handshake: the request is held with stable bus_* until bus_gnt_i is seen
  // high at a rising edge in REQ; afterwards exactly one bus_rvalid_i (loads
  // and stores alike) completes it, with bus_err_i qualifying that cycle.
  lsu_state_t  state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] aligned_data;
  logic        mis_now;
  logic        timed_out;

  assign mis_now     = is_misaligned(mem_funct3_i[1:0], mem_addr_i[1:0]);
  assign lsu_stall_o = ((state == ST_IDLE) && mem_req_i) ||
                       (state == ST_REQ) || (state == ST_RESP);
  assign dbg_state   = state;

  lsu_load_align u_align (
    .rdata  (bus_rdata_i),
    .offset (off_q),
    .funct3 (f3_q),
    .result (aligned_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wait_cnt;

  // REQ is only entered from IDLE, so clearing in IDLE restarts the count on entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == ST_IDLE) begin
      wait_cnt <= '0;
    end else if ((state == ST_REQ) || (state == ST_RESP)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timed_out = ((state == ST_REQ) || (state == ST_RESP)) && (wait_cnt == TO_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timed_out      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'b0;
      off_q        <= 2'b0;
      load_valid_o <= 1'b0;
      load_data_o  <= '0;
      misaligned_o <= 1'b0;
      bus_err_o    <= 1'b0;
      bus_req_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_addr_o   <= '0;
      bus_be_o     <= '0;
      bus_wdata_o  <= '0;
    end else begin
      load_valid_o <= 1'b0;
      if (timed_out) begin
        // Watchdog wins over a grant or response arriving in the same cycle.
        state        <= ST_DONE;
        bus_req_o    <= 1'b0;
        load_valid_o <= 1'b1;
        bus_err_o    <= 1'b1;
        load_data_o  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (mem_req_i) begin
              we_q  <= mem_we_i;
              f3_q  <= mem_funct3_i;
              off_q <= mem_addr_i[1:0];
              if (mis_now) begin
                state        <= ST_DONE;
                load_valid_o <= 1'b1;
                misaligned_o <= 1'b1;
                load_data_o  <= '0;
              end else begin
                state       <= ST_REQ;
                bus_req_o   <= 1'b1;
                bus_we_o    <= mem_we_i;
                bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                bus_be_o    <= mem_we_i ? store_be(mem_funct3_i[1:0], mem_addr_i[1:0]) : BE_WORD;
                bus_wdata_o <= mem_we_i ? store_wdata(mem_funct3_i[1:0], mem_wdata_i) : '0;
              end
            end
          end
          ST_REQ: begin
            if (bus_gnt_i) begin
              bus_req_o <= 1'b0;
              state     <= ST_RESP;
            end
          end
          ST_RESP: begin
            if (bus_rvalid_i) begin
              state        <= ST_DONE;
              load_valid_o <= 1'b1;
              bus_err_o    <= bus_err_i;
              load_data_o  <= (we_q || bus_err_i) ? '0 : aligned_data;
            end
          end
          ST_DONE: begin
            state        <= ST_IDLE;
            misaligned_o <= 1'b0;
            bus_err_o    <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed scenarios plus randomized accesses checked
// against an arithmetic reference model. Honours `define LSU_TIMEOUT_EN.
module tb_lsu_mem_stage;
  import rv32_lsu_pkg::*;

`ifdef LSU_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 1000000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req_i = 1'b0, mem_we_i = 1'b0;
  logic [2:0]  mem_funct3_i = '0;
  logic [31:0] mem_addr_i = '0, mem_wdata_i = '0;
  logic        lsu_stall_o, load_valid_o, misaligned_o, bus_err_o;
  logic [31:0] load_data_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i = 1'b0, bus_rvalid_i = 1'b0, bus_err_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;
  lsu_state_t  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  lsu_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_funct3_i(mem_funct3_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .lsu_stall_o(lsu_stall_o), .load_valid_o(load_valid_o), .load_data_o(load_data_o),
    .misaligned_o(misaligned_o), .bus_err_o(bus_err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .bus_err_i(bus_err_i), .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Observations from the most recent access
  int          obs_cycles, obs_valid_cnt, obs_req_cycles;
  logic        obs_req_seen, obs_stall_drop, obs_unstable, obs_expired;
  logic        obs_start_stall, obs_done_stall, obs_we, obs_mis, obs_err, obs_post_bad;
  logic [31:0] obs_addr, obs_wdata, obs_data;
  logic [3:0]  obs_be;

  // Reference model outputs
  int          exp_lat, exp_req_cycles;
  logic        exp_mis, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_data;
  logic [3:0]  exp_be;

  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                       input logic [31:0] rdata, input logic err);
    int nbytes, off, total;
    longint unit, rep, s, v;
    bit timed;
    nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(addr % 4);
    exp_mis = (addr % nbytes) != 0;
    exp_addr = addr - off;
    if (we) begin
      exp_be = 4'(((1 << nbytes) - 1) << off);
      unit = longint'(wdata) & ((64'd1 << (8 * nbytes)) - 1);
      rep = 0;
      for (int k = 0; k < 4 / nbytes; k++) rep = rep | (unit << (8 * nbytes * k));
      exp_wdata = rep[31:0];
    end else begin
      exp_be = 4'hF;
      exp_wdata = 32'h0;
    end
    total = gnt_dly + rv_dly + 2;
    timed = total >= TO;
    exp_req_cycles = exp_mis ? 0 : ((gnt_dly + 1 < TO) ? gnt_dly + 1 : TO);
    exp_lat = exp_mis ? 1 : (timed ? TO + 1 : total + 1);
    exp_err = !exp_mis && (timed || err);
    s = longint'(rdata) >> (8 * off);
    v = s % (64'd1 << (8 * nbytes));
    if (!f3[2] && nbytes < 4 && v >= (64'd1 << (8 * nbytes - 1))) v = v - (64'd1 << (8 * nbytes));
    exp_data = (we || exp_mis || exp_err) ? 32'h0 : v[31:0];
  endtask

  // Driver: issues one access and plays the bus slave with the given delays.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                            input logic [31:0] rdata, input logic err);
    bit gnt_driven = 0, in_resp = 0, done = 0;
    int resp_cnt = 0;
    obs_cycles = 0; obs_valid_cnt = 0; obs_req_cycles = 0;
    obs_req_seen = 0; obs_stall_drop = 0; obs_unstable = 0; obs_expired = 0;
    obs_done_stall = 0; obs_post_bad = 0;
    obs_we = 0; obs_mis = 0; obs_err = 0; obs_addr = 0; obs_wdata = 0; obs_data = 0; obs_be = 0;
    @(negedge clk);
    mem_req_i = 1'b1; mem_we_i = we; mem_funct3_i = f3; mem_addr_i = addr;
    mem_wdata_i = wdata; bus_rdata_i = rdata;
    #1 obs_start_stall = lsu_stall_o;
    for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
      @(posedge clk); #1;
      obs_cycles = cyc;
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
      if (gnt_driven) begin in_resp = 1; gnt_driven = 0; end
      if (load_valid_o) begin
        obs_valid_cnt++;
        obs_data = load_data_o; obs_mis = misaligned_o; obs_err = bus_err_o;
        obs_done_stall = lsu_stall_o;
        done = 1;
        mem_req_i = 1'b0;
      end else begin
        if (!lsu_stall_o) obs_stall_drop = 1;
        if (bus_req_o) begin
          if (!obs_req_seen) begin
            obs_addr = bus_addr_o; obs_be = bus_be_o; obs_wdata = bus_wdata_o; obs_we = bus_we_o;
          end else if (obs_addr !== bus_addr_o || obs_be !== bus_be_o ||
                       obs_wdata !== bus_wdata_o || obs_we !== bus_we_o) begin
            obs_unstable = 1;
          end
          obs_req_seen = 1;
          if (obs_req_cycles == gnt_dly) begin bus_gnt_i = 1'b1; gnt_driven = 1; end
          obs_req_cycles++;
        end else if (in_resp) begin
          if (resp_cnt == rv_dly) begin bus_rvalid_i = 1'b1; bus_err_i = err; end
          resp_cnt++;
        end
      end
    end
    if (!done) begin
      obs_expired = 1;
      mem_req_i = 1'b0;
    end
    @(posedge clk); #1;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
    if (load_valid_o || bus_req_o || lsu_stall_o || dbg_state !== ST_IDLE) obs_post_bad = 1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, load_valid_o,
         load_data_o, misaligned_o, bus_err_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero req=%b addr=%h be=%h data=%h required all 0",
                         bus_req_o, bus_addr_o, bus_be_o, load_data_o);
    end
    checks++;
    if (lsu_stall_o !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: stall=%b state=%0d required 0/IDLE", lsu_stall_o, dbg_state);
    end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_store_word();
    model(1'b1, F3_SW, 32'h100, 32'hDEADBEEF, 2, 0, 32'h0, 1'b0);
    run_access(1'b1, F3_SW, 32'h100, 32'hDEADBEEF, 2, 0, 32'h0, 1'b0);
    checks++;
    if (obs_start_stall !== 1'b1) begin errors++; $display("FAIL sw_stall_start: got %b required 1", obs_start_stall); end
    checks++;
    if (obs_addr !== 32'h100 || obs_be !== 4'hF || obs_wdata !== 32'hDEADBEEF || obs_we !== 1'b1) begin
      errors++; $display("FAIL sw_bus: got addr=%h be=%h wdata=%h we=%b required 100/f/deadbeef/1",
                         obs_addr, obs_be, obs_wdata, obs_we);
    end
    checks++;
    if (obs_lat_bad()) begin errors++; $display("FAIL sw_latency: got %0d required %0d", obs_cycles, exp_lat); end
    checks++;
    if (obs_stall_drop || obs_done_stall !== 1'b0 || obs_valid_cnt != 1 || obs_post_bad || obs_unstable) begin
      errors++; $display("FAIL sw_handshake: drop=%b done_stall=%b pulses=%0d post=%b unstable=%b required 0/0/1/0/0",
                         obs_stall_drop, obs_done_stall, obs_valid_cnt, obs_post_bad, obs_unstable);
    end
    checks++;
    if (obs_err !== exp_err || obs_data !== 32'h0) begin
      errors++; $display("FAIL sw_result: got err=%b data=%h required %b/0", obs_err, obs_data, exp_err);
    end
  endtask

  function automatic bit obs_lat_bad();
    return obs_expired || obs_cycles != exp_lat;
  endfunction

  task automatic test_load_extend();
    logic [2:0]  f3s[5] = '{F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LW};
    logic [31:0] addrs[5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h104};
    logic [31:0] rds[5] = '{32'h80FF1234, 32'h80FF1234, 32'h80010000, 32'h80010000, 32'h13579BDF};
    logic [31:0] want[5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'h13579BDF};
    logic [31:0] want_addr[5] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h104};
    for (int i = 0; i < 5; i++) begin
      run_access(1'b0, f3s[i], addrs[i], 32'h0, 0, 0, rds[i], 1'b0);
      checks++;
      if (obs_data !== want[i] || obs_err !== 1'b0 || obs_mis !== 1'b0) begin
        errors++; $display("FAIL load_ext_%0d: got data=%h err=%b mis=%b required %h/0/0",
                           i, obs_data, obs_err, obs_mis, want[i]);
      end
      checks++;
      if (obs_addr !== want_addr[i] || obs_be !== 4'hF || obs_wdata !== 32'h0 || obs_cycles != 3) begin
        errors++; $display("FAIL load_bus_%0d: got addr=%h be=%h wdata=%h lat=%0d required %h/f/0/3",
                           i, obs_addr, obs_be, obs_wdata, obs_cycles, want_addr[i]);
      end
    end
  endtask

  task automatic test_store_lanes_misaligned();
    run_access(1'b1, F3_SB, 32'h202, 32'h000000AB, 0, 0, 32'h0, 1'b0);
    checks++;
    if (obs_addr !== 32'h200 || obs_be !== 4'b0100 || obs_wdata !== 32'hABABABAB) begin
      errors++; $display("FAIL sb_lanes: got addr=%h be=%b wdata=%h required 200/0100/abababab",
                         obs_addr, obs_be, obs_wdata);
    end
    run_access(1'b1, F3_SH, 32'h101, 32'h0000BEEF, 0, 0, 32'h0, 1'b0);
    checks++;
    if (obs_mis !== 1'b1 || obs_req_seen !== 1'b0 || obs_cycles != 1 || obs_expired) begin
      errors++; $display("FAIL sh_misaligned: got mis=%b req_seen=%b lat=%0d required 1/0/1",
                         obs_mis, obs_req_seen, obs_cycles);
    end
    checks++;
    if (obs_err !== 1'b0 || obs_data !== 32'h0 || obs_done_stall !== 1'b0 || obs_post_bad) begin
      errors++; $display("FAIL sh_mis_flags: got err=%b data=%h stall=%b post=%b required 0/0/0/0",
                         obs_err, obs_data, obs_done_stall, obs_post_bad);
    end
  endtask

  task automatic test_bus_error();
    run_access(1'b0, F3_LW, 32'h308, 32'h0, 0, 1, 32'hCAFEF00D, 1'b1);
    checks++;
    if (obs_err !== 1'b1 || obs_data !== 32'h0 || obs_mis !== 1'b0 || obs_valid_cnt != 1) begin
      errors++; $display("FAIL bus_error: got err=%b data=%h mis=%b pulses=%0d required 1/0/0/1",
                         obs_err, obs_data, obs_mis, obs_valid_cnt);
    end
  endtask

  task automatic test_reset_mid_resp();
    bit stray = 0;
    @(negedge clk);
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_funct3_i = F3_LW; mem_addr_i = 32'h400;
    @(posedge clk); #1 bus_gnt_i = 1'b1;
    @(posedge clk); #1 bus_gnt_i = 1'b0;
    checks++;
    if (dbg_state !== ST_RESP || bus_req_o !== 1'b0) begin
      errors++; $display("FAIL rst_setup: got state=%0d req=%b required RESP/0", dbg_state, bus_req_o);
    end
    mem_req_i = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, load_valid_o,
         load_data_o, misaligned_o, bus_err_o, lsu_stall_o} !== '0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL rst_mid_resp: got state=%0d addr=%h req=%b stall=%b required IDLE/all 0",
                         dbg_state, bus_addr_o, bus_req_o, lsu_stall_o);
    end
    rst = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h55AA55AA;
    @(posedge clk); #1 bus_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (load_valid_o || dbg_state !== ST_IDLE || bus_req_o) stray = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (stray) begin errors++; $display("FAIL late_rvalid: got activity after reset required none"); end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    run_access(1'b0, F3_LW, 32'h500, 32'h0, 1000, 0, 32'h0, 1'b0);
    checks++;
    if (obs_req_cycles != 4 || obs_err !== 1'b1 || obs_cycles != 5 || obs_expired) begin
      errors++; $display("FAIL timeout: got req_cycles=%0d err=%b lat=%0d required 4/1/5",
                         obs_req_cycles, obs_err, obs_cycles);
    end
    checks++;
    if (obs_stall_drop || obs_done_stall !== 1'b0 || obs_post_bad || obs_data !== 32'h0) begin
      errors++; $display("FAIL timeout_stall: got drop=%b done_stall=%b post=%b data=%h required 0/0/0/0",
                         obs_stall_drop, obs_done_stall, obs_post_bad, obs_data);
    end
  endtask
`endif

  task automatic test_random();
    logic we, err;
    logic [2:0] f3;
    logic [31:0] addr, wdata, rdata, exp_pop;
    int gd, rd;
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom;
      wdata = $urandom;
      rdata = $urandom;
      gd = $urandom_range(0, 3);
      rd = $urandom_range(0, 3);
      err = ($urandom_range(0, 7) == 0);
      model(we, f3, addr, wdata, gd, rd, rdata, err);
      exp_q.push_back(exp_data);
      run_access(we, f3, addr, wdata, gd, rd, rdata, err);
      exp_pop = exp_q.pop_front();
      checks++;
      if (obs_data !== exp_pop || obs_mis !== exp_mis || obs_err !== exp_err) begin
        errors++; $display("FAIL rand_%0d_result: got data=%h mis=%b err=%b required %h/%b/%b (we=%b f3=%0d addr=%h)",
                           n, obs_data, obs_mis, obs_err, exp_pop, exp_mis, exp_err, we, f3, addr);
      end
      checks++;
      if (obs_lat_bad() || obs_req_cycles != exp_req_cycles || obs_valid_cnt != 1) begin
        errors++; $display("FAIL rand_%0d_timing: got lat=%0d req_cycles=%0d pulses=%0d required %0d/%0d/1",
                           n, obs_cycles, obs_req_cycles, obs_valid_cnt, exp_lat, exp_req_cycles);
      end
      checks++;
      if (obs_start_stall !== 1'b1 || obs_stall_drop || obs_done_stall !== 1'b0 || obs_post_bad || obs_unstable) begin
        errors++; $display("FAIL rand_%0d_stall: got start=%b drop=%b done=%b post=%b unstable=%b required 1/0/0/0/0",
                           n, obs_start_stall, obs_stall_drop, obs_done_stall, obs_post_bad, obs_unstable);
      end
      if (!exp_mis) begin
        checks++;
        if (obs_addr !== exp_addr || obs_be !== exp_be || obs_wdata !== exp_wdata || obs_we !== we) begin
          errors++; $display("FAIL rand_%0d_bus: got addr=%h be=%b wdata=%h we=%b required %h/%b/%h/%b",
                             n, obs_addr, obs_be, obs_wdata, obs_we, exp_addr, exp_be, exp_wdata, we);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_extend();
    test_store_lanes_misaligned();
    test_bus_error();
    test_reset_mid_resp();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
